// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/shift/compare ops plus
// iterative unsigned multiply/divide behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULLO = 4'd10;
  localparam logic [3:0] OP_MULHI = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_SLTU  = 4'd14;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     opd_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;

  logic                 accept;
  logic                 is_iter;
  logic                 last;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     dif;
  logic [SHW-1:0]       sh;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_ovf;

  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH:0]       madd;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       shl;
  logic [WIDTH:0]       dsub;
  logic                 ge;
  logic [WIDTH-1:0]     rem_n;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [WIDTH-1:0]     it_res;
  logic                 it_ovf;

  assign busy    = (state_q == EXEC);
  assign accept  = start && !busy;
  assign is_iter = (op >= OP_MULLO) && (op <= OP_REMU);
  assign last    = (cnt_q == SHW'(WIDTH - 1));
  assign sum     = A + B;
  assign dif     = A - B;
  assign sh      = A[SHW-1:0];

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                 (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR: sc_res = A ^ B;
      OP_NOR: sc_res = ~(A | B);
      OP_SRL: sc_res = B >> sh;
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                 (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         ($signed(A) < $signed(B))};
      OP_SLL:  sc_res = B << sh;
      OP_SRA:  sc_res = $signed(B) >>> sh;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: sc_res = '0;
    endcase
  end

  // acc holds {product hi, multiplier} or {remainder, quotient}
  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

  always_comb begin
    madd    = {1'b0, hi} + (lo[0] ? {1'b0, opd_q} : '0);
    mul_nxt = {madd, lo[WIDTH-1:1]};
    shl     = {hi, lo[WIDTH-1]};
    ge      = (shl >= {1'b0, opd_q});
    dsub    = shl - {1'b0, opd_q};
    rem_n   = ge ? dsub[WIDTH-1:0] : shl[WIDTH-1:0];
    div_nxt = {rem_n, lo[WIDTH-2:0], ge};
    acc_d   = (op_q[3:1] == 3'b101) ? mul_nxt : div_nxt;
  end

  always_comb begin
    it_res = '0;
    it_ovf = 1'b0;
    case (op_q)
      OP_MULLO: begin
        it_res = acc_d[WIDTH-1:0];
        it_ovf = |acc_d[2*WIDTH-1:WIDTH];
      end
      OP_MULHI: it_res = acc_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  it_res = acc_d[WIDTH-1:0];
      OP_REMU:  it_res = acc_d[2*WIDTH-1:WIDTH];
      default:  it_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_iter) state_d = EXEC;
      EXEC: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      done     <= 1'b0;
      res      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q <= op;
        if (is_iter) begin
          cnt_q <= '0;
          opd_q <= B;
          acc_q <= {{WIDTH{1'b0}}, A};
        end else begin
          res      <= sc_res;
          zero     <= (sc_res == '0);
          overflow <= sc_ovf;
          done     <= 1'b1;
        end
      end else if (busy) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + SHW'(1);
        if (last) begin
          res      <= it_res;
          zero     <= (it_res == '0);
          overflow <= it_ovf;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the single-cycle datapath ALU. It adds three things: configurable operand width, shift and compare variants, and an iterative unsigned multiply/divide unit. All results are registered behind a start/busy/done handshake. It sits in the execute stage, and the pipeline control stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width. Must be ≥ 8 and a power of two.
- `SHW`, default log2(`WIDTH`) (5 for 32): shift-amount width.
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high, sampled on the rising edge of `clk`.
- `start`  in  1: operation request. Sampled only when `busy`=0.
- `op`  in  4: operation select, captured with `start`.
- `A`  in  `WIDTH`: operand A, captured with `start`.
- `B`  in  `WIDTH`: operand B, captured with `start`.
- `busy`  out  1: an iterative operation is in progress.
- `done`  out  1: one-cycle pulse; `res`/`zero`/`overflow` were updated this cycle.
- `res`  out  `WIDTH`: registered result. Holds until the next `done`.
- `zero`  out  1: registered; 1 iff `res`==0.
- `overflow`  out  1: registered overflow flag; see Operation.

## Operation
- Single-cycle ops (codes 0–9, 14, 15):
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 ADD: A+B.
  - 3 XOR: A^B.
  - 4 NOR: ~(A|B).
  - 5 SRL: B >> A[SHW-1:0], logical.
  - 6 SUB: A−B.
  - 7 SLT: 1 if A<B signed, else 0.
  - 8 SLL: B << A[SHW-1:0].
  - 9 SRA: B >>> A[SHW-1:0], arithmetic.
  - 14 SLTU: 1 if A<B unsigned, else 0.
  - 15: reserved; `res`=0.
- Iterative ops (codes 10–13):
  - 10 MULLO: low `WIDTH` bits of the unsigned A×B.
  - 11 MULHI: high `WIDTH` bits of the unsigned A×B.
  - 12 DIVU: unsigned quotient A/B.
  - 13 REMU: unsigned remainder A%B.
- Multiply is radix-2 shift-add over a 2·`WIDTH` accumulator, one bit per cycle, `WIDTH` iterations.
- Divide is restoring, one quotient bit per cycle, `WIDTH` iterations.
- Divide by zero (B==0): quotient = all ones, remainder = A. Still takes the full `WIDTH` iterations.
- `overflow`:
  - ADD/SUB: two's-complement signed overflow, i.e. operand signs agree (for SUB: A's sign and the inverted B's sign) and the result sign differs.
  - MULLO: 1 iff the high half of the product ≠ 0.
  - All other ops: 0.
- Internal state machine:
  - IDLE → EXEC, when `start` is accepted with an iterative op.
  - EXEC counts `WIDTH` iterations, then → IDLE, loading outputs and pulsing `done`.
  - Single-cycle ops never leave IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `res`=0, `zero`=1, `overflow`=0. State goes to IDLE and the iteration counter to 0.
- Accept: `start`=1 with `busy`=0 at edge k. `A`/`B`/`op` are latched at k.
- Single-cycle op: `res`/`zero`/`overflow` are updated and `done`=1 after edge k, for exactly one cycle. `busy` stays 0.
- Back-to-back single-cycle ops: one per cycle, each with its own `done` pulse.
- Iterative op:
  - `busy`=1 after edges k … k+`WIDTH`−1.
  - At edge k+`WIDTH`: `busy`→0, `done`→1 for one cycle, outputs updated.
  - Latency is `WIDTH` cycles.
- A new `start` may be accepted in the same cycle that `done` is high, since `busy` is already 0.
- `start` while `busy`=1: ignored. No queuing and no effect on the operation in flight.
- Input changes to `A`/`B`/`op` during `busy`: no effect on the operation in flight.
- `rst` mid-operation: the operation is abandoned, outputs go to reset values at that edge, and no `done` is issued.
- `rst` and `start` on the same edge: `rst` wins and the request is dropped.

## Test plan
Scenarios use `WIDTH`=32.
- Reset, then ADD A=0x7FFFFFFF B=1 → one cycle later: `done`=1, `res`=0x80000000, `overflow`=1, `zero`=0, `busy` never 1.
- SUB A=5 B=5, then SLT A=0xFFFFFFFF B=1, then SLTU with the same operands on consecutive cycles → consecutive results: 0 with `zero`=1; then 1; then 0. Three `done` pulses.
- SRA A=4 B=0x80000000 → `res`=0xF8000000. SLL A=31 B=3 → `res`=0x80000000.
- MULHI A=B=0xFFFFFFFF → `busy` high exactly 32 cycles, then `done` with `res`=0xFFFFFFFE. MULLO on the same operands → `res`=1, `overflow`=1.
- DIVU A=100 B=7 → `res`=14 after 32 cycles. REMU on the same operands → 2. DIVU A=9 B=0 → 0xFFFFFFFF. REMU A=9 B=0 → 9.
- DIVU started, `start`+ADD pulsed at cycle 5 (ignored), `rst` at cycle 10 → no `done`, outputs at reset values, `busy`=0. A following ADD completes normally.
